// File: rtl/dot_acc_fxp_if.sv
// Handshake bundle for the dot-product accumulator: element-pair input
// stream (x, w, last) and result output stream (data, sat, cnt).
interface dot_acc_fxp_if #(
    parameter int L_PREC = 32,
    parameter int CNT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [L_PREC-1:0] in_x;
    logic signed [L_PREC-1:0] in_w;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [L_PREC-1:0] out_data;
    logic                     out_sat;
    logic [CNT_W-1:0]         out_cnt;

    // Producer of pairs / consumer of results
    modport master (
        output in_valid, in_x, in_w, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_cnt
    );

    // The accumulator itself
    modport slave (
        input  in_valid, in_x, in_w, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_cnt
    );
endinterface

// File: rtl/dot_acc_fxp.sv
// Sequential saturating dot-product accumulator in long signed fixed point.
// Each accepted pair is multiplied, realigned to L_FRAC fractional bits,
// and added into a saturating accumulator; one registered result is
// presented per vector (delimited by in_last) through a valid/ready port.
module dot_acc_fxp #(
    parameter int L_PREC = 32,
    parameter int L_FRAC = 16,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         reset,
    dot_acc_fxp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic signed [L_PREC-1:0] MAX_V = {1'b0, {(L_PREC-1){1'b1}}};
    localparam logic signed [L_PREC-1:0] MIN_V = {1'b1, {(L_PREC-1){1'b0}}};
    localparam logic [CNT_W-1:0]         ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    // Product shifted back to L_FRAC fraction bits does not fit L_PREC
    function automatic logic realign_ovf(input logic signed [2*L_PREC-1:0] p);
        logic signed [2*L_PREC-1:0] pa;
        pa = p >>> L_FRAC;
        return !((&pa[2*L_PREC-1:L_PREC-1]) || (~|pa[2*L_PREC-1:L_PREC-1]));
    endfunction

    // Realign product to the long format, clamping by the sign of the product
    function automatic logic signed [L_PREC-1:0] realign_sat(input logic signed [2*L_PREC-1:0] p);
        logic signed [2*L_PREC-1:0] pa;
        pa = p >>> L_FRAC;
        if (realign_ovf(p)) begin
            return p[2*L_PREC-1] ? MIN_V : MAX_V;
        end
        return pa[L_PREC-1:0];
    endfunction

    // Signed overflow of a + b
    function automatic logic add_ovf(input logic signed [L_PREC-1:0] a,
                                     input logic signed [L_PREC-1:0] b);
        logic [L_PREC:0] s;
        s = {a[L_PREC-1], a} + {b[L_PREC-1], b};
        return s[L_PREC] ^ s[L_PREC-1];
    endfunction

    // Saturating a + b; the extra sign bit gives the direction of overflow
    function automatic logic signed [L_PREC-1:0] add_sat(input logic signed [L_PREC-1:0] a,
                                                         input logic signed [L_PREC-1:0] b);
        logic [L_PREC:0] s;
        s = {a[L_PREC-1], a} + {b[L_PREC-1], b};
        if (s[L_PREC] ^ s[L_PREC-1]) begin
            return s[L_PREC] ? MIN_V : MAX_V;
        end
        return s[L_PREC-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic signed [L_PREC-1:0]   acc_q, acc_d;
    logic                       sat_q, sat_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [L_PREC-1:0]   out_data_q, out_data_d;
    logic                       out_sat_q, out_sat_d;
    logic [CNT_W-1:0]           out_cnt_q, out_cnt_d;

    logic                       accept;
    logic                       first;
    logic signed [2*L_PREC-1:0] prod;
    logic signed [L_PREC-1:0]   pa;
    logic signed [L_PREC-1:0]   base;
    logic signed [L_PREC-1:0]   sum;
    logic                       sat_next;
    logic [CNT_W-1:0]           cnt_next;

    assign bus.in_ready  = (state_q != OUT);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_cnt   = out_cnt_q;

    // Next-state, datapath and result capture; the first pair of a vector restarts from zero
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        out_cnt_d  = out_cnt_q;

        accept   = bus.in_valid && (state_q != OUT);
        first    = (state_q == IDLE);
        prod     = bus.in_x * bus.in_w;
        pa       = realign_sat(prod);
        base     = first ? '0 : acc_q;
        sum      = add_sat(base, pa);
        sat_next = (!first && sat_q) || realign_ovf(prod) || add_ovf(base, pa);
        cnt_next = first ? ONE_C : ((&cnt_q) ? cnt_q : cnt_q + ONE_C);

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sum;
                    sat_d = sat_next;
                    cnt_d = cnt_next;
                    if (bus.in_last) begin
                        state_d    = OUT;
                        out_data_d = sum;
                        out_sat_d  = sat_next;
                        out_cnt_d  = cnt_next;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_cnt_q  <= out_cnt_d;
        end
    end
endmodule

// File: tb/tb_dot_acc_fxp.sv
// Self-checking bench for dot_acc_fxp: directed vectors with literal
// expectations plus randomized vectors checked every cycle against a
// plain-arithmetic model of the accumulator.
module tb_dot_acc_fxp;
    localparam int     L_PREC  = 32;
    localparam int     L_FRAC  = 16;
    localparam int     CNT_W   = 4;
    localparam int     CNT_MAX = (1 << CNT_W) - 1;
    localparam longint MAXV    = 64'sd2147483647;
    localparam longint MINV    = -64'sd2147483648;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    dot_acc_fxp_if #(.L_PREC(L_PREC), .CNT_W(CNT_W)) bus();

    dot_acc_fxp #(.L_PREC(L_PREC), .L_FRAC(L_FRAC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit     m_busy, m_in_vec, m_sat, e_sat;
    longint m_acc, e_data;
    int     m_cnt, e_cnt;

    task automatic m_clear();
        m_busy = 0; m_in_vec = 0; m_sat = 0; m_acc = 0; m_cnt = 0;
        e_data = 0; e_sat = 0; e_cnt = 0;
    endtask

    task automatic m_accept();
        longint p, pa, base, s;
        bit     ovf;
        int     c;
        p   = longint'(bus.in_x) * longint'(bus.in_w);
        pa  = p >>> L_FRAC;
        ovf = 0;
        if (pa > MAXV) begin pa = MAXV; ovf = 1; end
        else if (pa < MINV) begin pa = MINV; ovf = 1; end
        base = m_in_vec ? m_acc : 64'sd0;
        s    = base + pa;
        if (s > MAXV) begin s = MAXV; ovf = 1; end
        else if (s < MINV) begin s = MINV; ovf = 1; end
        c = !m_in_vec ? 1 : ((m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1);
        m_sat = (m_in_vec && m_sat) || ovf;
        m_acc = s;
        m_cnt = c;
        if (bus.in_last) begin
            m_busy = 1; m_in_vec = 0;
            e_data = s; e_sat = m_sat; e_cnt = c;
        end else begin
            m_in_vec = 1;
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_clear();
            else if (m_busy) begin
                if (bus.out_ready) m_busy = 0;
            end else if (bus.in_valid) begin
                m_accept();
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: handshake timed out at %0t", name, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready",  32'(bus.in_ready),  32'(!m_busy));
            chk("out_valid", 32'(bus.out_valid), 32'(m_busy));
            chk("out_data",  bus.out_data,       e_data[31:0]);
            chk("out_sat",   32'(bus.out_sat),   32'(e_sat));
            chk("out_cnt",   32'(bus.out_cnt),   e_cnt);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1, 2:    return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            default: return ($urandom_range(0, 1) ? 32'h7FFF_0000 : 32'h8000_0000)
                            | ($urandom & 32'h0000_FFFF);
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] w, input logic last);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_x = x; bus.in_w = w; bus.in_last = last;
        for (int i = 0; i < 200; i++) begin
            ok = bus.in_ready;
            cyc();
            if (ok) break;
        end
        if (!ok) timeout("send");
        bus.in_valid = 1'b0;
        bus.in_x = $urandom; bus.in_w = $urandom; bus.in_last = 1'($urandom);
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.out_valid) begin ok = 1'b1; break; end
            cyc();
        end
        if (!ok) timeout("wait_valid");
    endtask

    task automatic pop(input int delay);
        logic ok;
        wait_valid(ok);
        repeat (delay) cyc();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] d, input logic s, input int c);
        logic ok;
        wait_valid(ok);
        if (ok) begin
            chk({name, "_data"},   bus.out_data,      d);
            chk({name, "_sat"},    32'(bus.out_sat),  32'(s));
            chk({name, "_cnt"},    32'(bus.out_cnt),  c);
            chk({name, "_m_data"}, e_data[31:0],      d);
        end
        pop(0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_w = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'd1);
        chk("rst_data",  bus.out_data,       32'd0);
        chk("rst_cnt",   32'(bus.out_cnt),   32'd0);
        cyc();

        // 2.0 + (0.5 * -4.0) = 0, with one-cycle output latency
        send(32'h0001_0000, 32'h0002_0000, 1'b0);
        chk("lat_before", 32'(bus.out_valid), 32'd0);
        send(32'h0000_8000, 32'hFFFC_0000, 1'b1);
        chk("lat_after",  32'(bus.out_valid), 32'd1);
        expect_out("v_zero", 32'h0000_0000, 1'b0, 2);

        // single-element vector: 3.0 * 0.25
        send(32'h0003_0000, 32'h0000_4000, 1'b1);
        expect_out("v_single", 32'h0000_C000, 1'b0, 1);

        // positive accumulate overflow, then sat flag cleared by next vector
        send(32'h7FFF_0000, 32'h0001_0000, 1'b0);
        send(32'h7FFF_0000, 32'h0001_0000, 1'b1);
        expect_out("v_satpos", 32'h7FFF_FFFF, 1'b1, 2);
        send(32'h0001_0000, 32'h0001_0000, 1'b1);
        expect_out("v_clr", 32'h0001_0000, 1'b0, 1);

        // product realignment underflow clamps to MIN
        send(32'h8000_0000, 32'h7FFF_0000, 1'b1);
        expect_out("v_satneg", 32'h8000_0000, 1'b1, 1);

        // downstream stall: pending pair must wait, outputs stable
        send(32'h0001_0000, 32'h0001_0000, 1'b1);
        bus.in_valid = 1'b1; bus.in_x = 32'h0002_0000; bus.in_w = 32'h0001_0000; bus.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", 32'(bus.in_ready),  32'd0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_data",  bus.out_data,       32'h0001_0000);
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("stall_release", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        expect_out("v_after_stall", 32'h0002_0000, 1'b0, 1);

        // bubbles between pairs, with garbage on the ignored inputs
        send(32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (2) cyc();
        send(32'h0001_0000, 32'h0001_0000, 1'b0);
        cyc();
        send(32'h0001_0000, 32'h0001_0000, 1'b1);
        expect_out("v_bubble", 32'h0003_0000, 1'b0, 3);

        // counter saturates at all-ones
        for (int i = 0; i < 20; i++) send(32'h0001_0000, 32'h0001_0000, 1'(i == 19));
        expect_out("v_cntsat", 32'h0014_0000, 1'b0, CNT_MAX);

        // reset mid-vector discards the partial sum immediately
        send(32'h0001_0000, 32'h0001_0000, 1'b0);
        send(32'h0001_0000, 32'h0001_0000, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data",  bus.out_data,       32'd0);
        chk("mid_rst_cnt",   32'(bus.out_cnt),   32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        send(32'h0001_0000, 32'h0001_0000, 1'b1);
        expect_out("v_post_rst", 32'h0001_0000, 1'b0, 1);

        // randomized vectors, bubbles and output back-pressure
        for (int v = 0; v < 60; v++) begin
            int len;
            len = (v % 15 == 14) ? 18 : int'($urandom_range(1, 6));
            for (int e = 0; e < len; e++) begin
                repeat ($urandom_range(0, 2)) cyc();
                send(rnd_val(), rnd_val(), 1'(e == len - 1));
            end
            pop(int'($urandom_range(0, 3)));
        end

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
